// File: rtl/atm_pkg.sv
// Shared ATM definitions: one-hot controller states, datapath status codes,
// menu option codes and currency codes used by controller and datapath.
package atm_pkg;

  // One-hot controller state; the encoding is visible to the datapath.
  typedef enum logic [15:0] {
    ST_IDLE                      = 16'h0001,
    ST_ACC_NUM                   = 16'h0002,
    ST_PIN_INPUT                 = 16'h0004,
    ST_MENU                      = 16'h0008,
    ST_SHOW_BALANCES             = 16'h0010,
    ST_SELECT_CURRENCY_CONVERT_1 = 16'h0040,
    ST_SELECT_CURRENCY_CONVERT_2 = 16'h0080,
    ST_SELECT_AMOUNT_WITHDRAW    = 16'h0200,
    ST_TRANSFER                  = 16'h0400,
    ST_SELECT_AMOUNT_TRANSFER    = 16'h1000,
    ST_ERROR                     = 16'h2000,
    ST_SUCCESS                   = 16'h4000
  } atm_state_e;

  // Datapath result codes
  localparam logic [3:0] STAT_ACC_FOUND     = 4'd1;
  localparam logic [3:0] STAT_ACC_NOT_FOUND = 4'd2;
  localparam logic [3:0] STAT_PIN_CORRECT   = 4'd3;
  localparam logic [3:0] STAT_PIN_INCORRECT = 4'd4;
  localparam logic [3:0] STAT_AMT_VALID     = 4'd5;
  localparam logic [3:0] STAT_AMT_INVALID   = 4'd6;

  // Menu selections
  localparam logic [1:0] OPT_BALANCES = 2'b00;
  localparam logic [1:0] OPT_CONVERT  = 2'b01;
  localparam logic [1:0] OPT_WITHDRAW = 2'b10;
  localparam logic [1:0] OPT_TRANSFER = 2'b11;

  // Currency codes understood by the datapath
  localparam logic [2:0] CUR_USD = 3'd0;
  localparam logic [2:0] CUR_BTC = 3'd1;
  localparam logic [2:0] CUR_ETH = 3'd2;

  // States in which enter launches a datapath request
  function automatic logic is_request_state(input atm_state_e s);
    return s inside {ST_ACC_NUM, ST_PIN_INPUT, ST_SELECT_CURRENCY_CONVERT_1,
                     ST_SELECT_CURRENCY_CONVERT_2, ST_SELECT_AMOUNT_WITHDRAW,
                     ST_TRANSFER, ST_SELECT_AMOUNT_TRANSFER};
  endfunction

endpackage

// File: rtl/atm_idle_timer.sv
// Inactivity counter: counts cycles since the last clear and flags expiry
// once LIMIT-1 is reached. hold freezes the count without clearing it.
module atm_idle_timer #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic expire
);

  localparam int              CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // A held counter never expires, so a frozen value cannot force a logout.
  assign expire = !hold && (cnt_q == LAST);

  // Count up; restart after expiry so the next session starts fresh.
  always_ff @(posedge clk) begin
    if (reset || clear || expire) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/atm_controller.sv
// ATM session controller: one-hot FSM sequencing login, menu and
// transaction requests to the datapath via a ready/status handshake.
// Optional inactivity logout is built when ATM_TIMEOUT_EN is defined.
// MAX_PIN_TRIES must lie in 1..3 (2-bit try counter).
module atm_controller
  import atm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_PIN_TRIES  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enter,
  input  logic        back,
  input  logic [1:0]  menu_option,
  input  logic [3:0]  status_code,
  output logic [15:0] current_state,
  output logic        ready,
  output logic        authenticated,
  output logic        locked
);

  atm_state_e state_q, state_nxt;
  logic       rdy_p1, rdy_nxt;     // request issued; ready visible to datapath
  logic       samp_p2, samp_nxt;   // status_code sampled this cycle
  logic       auth_q, auth_nxt;
  logic       lock_q, lock_nxt;
  logic [1:0] tries_q, tries_nxt;
  logic [2:0] tries_inc;
  logic       timeout;

`ifdef ATM_TIMEOUT_EN
  logic tmr_clear;
  logic tmr_hold;

  // Any user action or sitting in IDLE restarts the inactivity window;
  // a locked ERROR state waits for reset and must not time out.
  assign tmr_clear = enter | back | (state_q == ST_IDLE);
  assign tmr_hold  = lock_q & (state_q == ST_ERROR);

  atm_idle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .hold   (tmr_hold),
    .expire (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign current_state = state_q;
  assign ready         = rdy_p1;
  assign authenticated = auth_q;
  assign locked        = lock_q;

  // State and request-phase registers; reset abandons any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rdy_p1  <= 1'b0;
      samp_p2 <= 1'b0;
      auth_q  <= 1'b0;
      lock_q  <= 1'b0;
      tries_q <= '0;
    end else begin
      state_q <= state_nxt;
      rdy_p1  <= rdy_nxt;
      samp_p2 <= samp_nxt;
      auth_q  <= auth_nxt;
      lock_q  <= lock_nxt;
      tries_q <= tries_nxt;
    end
  end

  // Next state: timeout, then status sampling, then ready cycle, then back, then enter.
  always_comb begin
    state_nxt = state_q;
    rdy_nxt   = 1'b0;
    samp_nxt  = 1'b0;
    auth_nxt  = auth_q;
    lock_nxt  = lock_q;
    tries_nxt = tries_q;
    tries_inc = {1'b0, tries_q} + 3'd1;

    if (timeout) begin
      state_nxt = ST_IDLE;
    end else if (samp_p2) begin
      case (state_q)
        ST_ACC_NUM:
          state_nxt = (status_code == STAT_ACC_FOUND) ? ST_PIN_INPUT : ST_ERROR;
        ST_PIN_INPUT: begin
          if (status_code == STAT_PIN_CORRECT) begin
            state_nxt = ST_MENU;
            auth_nxt  = 1'b1;
            tries_nxt = '0;
          end else if (status_code == STAT_PIN_INCORRECT) begin
            tries_nxt = tries_inc[1:0];
            if (int'(tries_inc) >= MAX_PIN_TRIES) begin
              state_nxt = ST_ERROR;
              lock_nxt  = 1'b1;
            end
          end else begin
            state_nxt = ST_ERROR;
          end
        end
        ST_SELECT_CURRENCY_CONVERT_1:
          state_nxt = (status_code == STAT_AMT_VALID) ? ST_SELECT_CURRENCY_CONVERT_2 : ST_ERROR;
        ST_SELECT_CURRENCY_CONVERT_2:
          state_nxt = ST_SUCCESS;
        ST_SELECT_AMOUNT_WITHDRAW, ST_SELECT_AMOUNT_TRANSFER:
          state_nxt = (status_code == STAT_AMT_VALID) ? ST_SUCCESS : ST_ERROR;
        ST_TRANSFER:
          state_nxt = (status_code == STAT_ACC_FOUND) ? ST_SELECT_AMOUNT_TRANSFER : ST_ERROR;
        default:
          state_nxt = ST_ERROR;
      endcase
    end else if (rdy_p1) begin
      samp_nxt = 1'b1;
    end else if (back) begin
      case (state_q)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_ACC_NUM, ST_PIN_INPUT, ST_MENU: state_nxt = ST_IDLE;
        ST_ERROR: begin
          if (!lock_q) state_nxt = auth_q ? ST_MENU : ST_IDLE;
        end
        default: state_nxt = auth_q ? ST_MENU : ST_IDLE;
      endcase
    end else if (enter) begin
      case (state_q)
        ST_IDLE: state_nxt = ST_ACC_NUM;
        ST_MENU: begin
          case (menu_option)
            OPT_BALANCES: state_nxt = ST_SHOW_BALANCES;
            OPT_CONVERT:  state_nxt = ST_SELECT_CURRENCY_CONVERT_1;
            OPT_WITHDRAW: state_nxt = ST_SELECT_AMOUNT_WITHDRAW;
            default:      state_nxt = ST_TRANSFER;
          endcase
        end
        ST_SHOW_BALANCES, ST_SUCCESS: state_nxt = ST_MENU;
        ST_ERROR: begin
          if (!lock_q) state_nxt = auth_q ? ST_MENU : ST_IDLE;
        end
        default: rdy_nxt = is_request_state(state_q);
      endcase
    end

    // A fresh session never inherits credentials or PIN failures.
    if (state_nxt == ST_IDLE) begin
      auth_nxt  = 1'b0;
      tries_nxt = '0;
    end
  end

endmodule

// File: tb/tb_atm_controller.sv
// Self-checking bench for atm_controller: directed scenarios followed by a
// random walk, all predicted by a transaction-level session model.
module tb_atm_controller;
  import atm_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enter = 1'b0;
  logic        back = 1'b0;
  logic [1:0]  menu_option = 2'b00;
  logic [3:0]  status_code = 4'd0;
  logic [15:0] current_state;
  logic        ready, authenticated, locked;

  int checks = 0;
  int errors = 0;

  // Session model
  logic [15:0] m_state;
  bit          m_auth, m_lock;
  int          m_tries;

  typedef struct { logic [15:0] from; logic [3:0] code; logic [15:0] to; } rule_t;
  rule_t       rules[$];
  logic [15:0] opt_dest[4];

  atm_controller #(.TIMEOUT_CYCLES(TO), .MAX_PIN_TRIES(3)) dut (
    .clk(clk), .reset(reset), .enter(enter), .back(back),
    .menu_option(menu_option), .status_code(status_code),
    .current_state(current_state), .ready(ready),
    .authenticated(authenticated), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    status_code = 4'($urandom_range(0, 15));
  endtask

  task automatic add_rule(input logic [15:0] f, input logic [3:0] c, input logic [15:0] t);
    rule_t r;
    r.from = f; r.code = c; r.to = t;
    rules.push_back(r);
  endtask

  task automatic go_idle();
    m_state = ST_IDLE; m_auth = 0; m_tries = 0;
  endtask

  function automatic bit is_req(input logic [15:0] s);
    return s inside {ST_ACC_NUM, ST_PIN_INPUT, ST_SELECT_CURRENCY_CONVERT_1,
                     ST_SELECT_CURRENCY_CONVERT_2, ST_SELECT_AMOUNT_WITHDRAW,
                     ST_TRANSFER, ST_SELECT_AMOUNT_TRANSFER};
  endfunction

  task automatic check_model(input string tag, input logic exp_ready);
    check({tag, ".state"},  32'(current_state), 32'(m_state));
    check({tag, ".ready"},  32'(ready),         32'(exp_ready));
    check({tag, ".auth"},   32'(authenticated), 32'(m_auth));
    check({tag, ".locked"}, 32'(locked),        32'(m_lock));
  endtask

  // Outcome of a datapath answer, from the per-state rule table.
  task automatic model_resolve(input logic [3:0] st);
    logic [15:0] dest;
    bit hit;
    dest = ST_ERROR;
    hit  = 0;
    if (m_state == ST_SELECT_CURRENCY_CONVERT_2) begin
      dest = ST_SUCCESS; hit = 1;
    end
    foreach (rules[k]) begin
      if (!hit && rules[k].from == m_state && rules[k].code == st) begin
        dest = rules[k].to; hit = 1;
      end
    end
    if (m_state == ST_PIN_INPUT && st == 4'd3) begin
      m_auth = 1; m_tries = 0;
    end
    if (m_state == ST_PIN_INPUT && st == 4'd4) begin
      m_tries = m_tries + 1;
      if (m_tries >= 3) begin
        dest = ST_ERROR; m_lock = 1;
      end else begin
        dest = ST_PIN_INPUT;
      end
    end
    m_state = dest;
  endtask

  // Outcome of a user action outside a request.
  task automatic model_user(input bit e, input bit b, input logic [1:0] opt);
    if (m_state == ST_ERROR && m_lock) return;
    if (b) begin
      if (m_state == ST_IDLE) return;
      if (m_state inside {ST_ACC_NUM, ST_PIN_INPUT, ST_MENU}) go_idle();
      else if (m_auth) m_state = ST_MENU;
      else go_idle();
    end else if (e) begin
      case (m_state)
        ST_IDLE:                     m_state = ST_ACC_NUM;
        ST_MENU:                     m_state = opt_dest[opt];
        ST_SHOW_BALANCES, ST_SUCCESS: m_state = ST_MENU;
        ST_ERROR: if (m_auth) m_state = ST_MENU; else go_idle();
        default: ;
      endcase
    end
  endtask

  task automatic act(input string tag, input bit e, input bit b, input logic [1:0] opt);
    menu_option = opt; enter = e; back = b;
    tick();
    enter = 0; back = 0;
    model_user(e, b, opt);
    check_model(tag, 1'b0);
  endtask

  // Full request: enter, ready cycle, sampling cycle, resolution.
  task automatic request(input string tag, input logic [3:0] st, input bit noise);
    logic [15:0] held;
    held = m_state;
    enter = 1; back = 0;
    tick();
    enter = noise; back = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    check({tag, ".rdy1"},  32'(ready), 32'd1);
    check({tag, ".hold1"}, 32'(current_state), 32'(held));
    tick();
    status_code = st;
    enter = noise; back = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    check({tag, ".rdy2"},  32'(ready), 32'd0);
    check({tag, ".hold2"}, 32'(current_state), 32'(held));
    tick();
    enter = 0; back = 0;
    model_resolve(st);
    check_model({tag, ".res"}, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1; enter = 0; back = 0;
    tick();
    reset = 0;
    go_idle(); m_lock = 0;
    check_model(tag, 1'b0);
  endtask

  function automatic logic [3:0] pick_status(input logic [15:0] s);
    int r;
    logic [3:0] good, alt;
    r = int'($urandom_range(0, 9));
    case (s)
      ST_ACC_NUM, ST_TRANSFER: begin good = 4'd1; alt = 4'd2; end
      ST_PIN_INPUT:            begin good = 4'd3; alt = 4'd4; end
      default:                 begin good = 4'd5; alt = 4'd6; end
    endcase
    if (r < 5) return good;
    if (r < 8) return alt;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    add_rule(ST_ACC_NUM, 4'd1, ST_PIN_INPUT);
    add_rule(ST_PIN_INPUT, 4'd3, ST_MENU);
    add_rule(ST_SELECT_CURRENCY_CONVERT_1, 4'd5, ST_SELECT_CURRENCY_CONVERT_2);
    add_rule(ST_SELECT_AMOUNT_WITHDRAW, 4'd5, ST_SUCCESS);
    add_rule(ST_SELECT_AMOUNT_TRANSFER, 4'd5, ST_SUCCESS);
    add_rule(ST_TRANSFER, 4'd1, ST_SELECT_AMOUNT_TRANSFER);
    opt_dest[0] = ST_SHOW_BALANCES;
    opt_dest[1] = ST_SELECT_CURRENCY_CONVERT_1;
    opt_dest[2] = ST_SELECT_AMOUNT_WITHDRAW;
    opt_dest[3] = ST_TRANSFER;
    m_lock = 0;
    go_idle();

    do_reset("reset0");

    // Login
    act("login.enter", 1, 0, 2'b00);
    request("login.acc", 4'd1, 0);
    request("login.pin", 4'd3, 0);

    // Withdraw, valid then invalid amount
    act("wd.sel", 1, 0, 2'b10);
    request("wd.ok", 4'd5, 0);
    act("wd.done", 1, 0, 2'b00);
    act("wd2.sel", 1, 0, 2'b10);
    request("wd2.bad", 4'd6, 0);
    act("wd2.done", 1, 0, 2'b00);

    // Conflicts
    act("xf.sel", 1, 0, 2'b11);
    act("xf.entback", 1, 1, 2'b00);
    act("wd3.sel", 1, 0, 2'b10);
    request("wd3.noise", 4'd5, 1);
    act("wd3.done", 1, 0, 2'b00);
    act("wd4.sel", 1, 0, 2'b10);
    request("wd4.unexp", 4'd1, 0);
    act("wd4.done", 1, 0, 2'b00);

    // Inactivity in MENU
    act("to.sel", 1, 0, 2'b00);
    act("to.menu", 1, 0, 2'b00);
    repeat (TO) tick();
`ifdef ATM_TIMEOUT_EN
    go_idle();
`endif
    check_model("timeout", 1'b0);

    // Lockout
    act("lk.back", 0, 1, 2'b00);
    act("lk.enter", 1, 0, 2'b00);
    request("lk.acc", 4'd1, 0);
    request("lk.pin1", 4'd4, 0);
    request("lk.pin2", 4'd4, 0);
    request("lk.pin3", 4'd4, 0);
    act("lk.ign_enter", 1, 0, 2'b00);
    act("lk.ign_back", 0, 1, 2'b00);
    do_reset("lk.reset");

    // Reset in the middle of a request
    act("rq.enter", 1, 0, 2'b00);
    enter = 1;
    tick();
    enter = 0;
    check("rq.rdy", 32'(ready), 32'd1);
    reset = 1;
    tick();
    reset = 0;
    go_idle(); m_lock = 0;
    check_model("rq.after", 1'b0);
    status_code = 4'd1;
    tick();
    tick();
    check_model("rq.later", 1'b0);

    // Random walk
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0 || (m_lock && $urandom_range(0, 3) == 0)) begin
        do_reset("walk.reset");
      end else if (is_req(m_state) && $urandom_range(0, 4) != 0) begin
        request("walk.req", pick_status(m_state), 1'($urandom_range(0, 1)));
      end else begin
        int r;
        bit e, b;
        r = int'($urandom_range(0, 3));
        b = (r <= 1);
        e = (r >= 1);
        if (is_req(m_state)) b = 1;
        act("walk.act", e, b, 2'($urandom_range(0, 3)));
      end
      repeat ($urandom_range(0, 2)) tick();
      check_model("walk.gap", 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/atm_controller.md
ATM_CONTROLLER -- requirements
Module: atm_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: idle cycles before forced logout.
REQ-002 Parameter MAX_PIN_TRIES, default 3: PIN failures before lock.
REQ-003 clk  in  1  sole clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 enter  in  1  user confirm; single-cycle, pre-debounced pulse.
REQ-006 back  in  1  user cancel; single-cycle, pre-debounced pulse.
REQ-007 menu_option  in  2  00 balances, 01 convert, 10 withdraw, 11 transfer.
REQ-008 status_code  in  4  datapath result code: 1 ACC_FOUND, 2 ACC_NOT_FOUND, 3 PIN_CORRECT, 4 PIN_INCORRECT, 5 AMT_VALID, 6 AMT_INVALID.
REQ-009 current_state  out  16  one-hot state driving the datapath.
REQ-010 ready  out  1  one-cycle request to the datapath.
REQ-011 authenticated  out  1  session holds a verified PIN.
REQ-012 locked  out  1  PIN lockout active.

Function
REQ-013 States: IDLE 0x0001, ACC_NUM 0x0002, PIN_INPUT 0x0004, MENU 0x0008, SHOW_BALANCES 0x0010, SELECT_CURRENCY_CONVERT_1 0x0040, SELECT_CURRENCY_CONVERT_2 0x0080, SELECT_AMOUNT_WITHDRAW 0x0200, TRANSFER 0x0400, SELECT_AMOUNT_TRANSFER 0x1000, ERROR 0x2000, SUCCESS 0x4000. current_state SHALL be exactly one of these.
REQ-014 Request states (ACC_NUM, PIN_INPUT, CONVERT_1, CONVERT_2, WITHDRAW, TRANSFER, AMOUNT_TRANSFER): enter in cycle N raises ready in N+1 only. status_code is sampled in N+2 and the next state is taken in N+3. current_state SHALL be held from N through N+2.
REQ-015 While a request is outstanding (ready high or sampling cycle), enter and back SHALL be ignored.
REQ-016 IDLE: enter -> ACC_NUM, with no ready.
REQ-017 ACC_NUM: ACC_FOUND -> PIN_INPUT; ACC_NOT_FOUND -> ERROR.
REQ-018 PIN_INPUT: PIN_CORRECT -> MENU, sets authenticated and clears the try count. PIN_INCORRECT increments the 2-bit try count. If the count reaches MAX_PIN_TRIES -> ERROR with locked=1; otherwise stay in PIN_INPUT.
REQ-019 MENU: enter selects by menu_option: 00 SHOW_BALANCES, 01 SELECT_CURRENCY_CONVERT_1, 10 SELECT_AMOUNT_WITHDRAW, 11 TRANSFER. No ready is issued.
REQ-020 SHOW_BALANCES: enter -> MENU.
REQ-021 CONVERT_1: AMT_VALID -> CONVERT_2; AMT_INVALID -> ERROR. CONVERT_2: -> SUCCESS regardless of status_code.
REQ-022 WITHDRAW and AMOUNT_TRANSFER: AMT_VALID -> SUCCESS; AMT_INVALID -> ERROR. TRANSFER: ACC_FOUND -> AMOUNT_TRANSFER; ACC_NOT_FOUND -> ERROR.
REQ-023 Any status_code that is unexpected for the current state at sampling -> ERROR.
REQ-024 SUCCESS: enter -> MENU.
REQ-025 ERROR: enter -> MENU if authenticated, else IDLE. If locked, enter and back SHALL be ignored; exit is by reset only.
REQ-026 back handling:
- In ACC_NUM, PIN_INPUT or MENU: -> IDLE, clears authenticated and the try count.
- In other authenticated non-IDLE states: -> MENU.
- If enter and back arrive in the same cycle, back wins.
REQ-027 Entering IDLE by any path SHALL clear authenticated.

Reset
REQ-028 reset SHALL force current_state=IDLE, ready=0, authenticated=0, locked=0, try count=0 and idle timer=0 on the next edge.
REQ-029 Reset mid-request SHALL abandon the request; ready is 0 in the cycle after reset.

Configuration
REQ-030 Macro ATM_TIMEOUT_EN defined:
- An idle counter clears on enter, on back, and in IDLE.
- It increments each cycle otherwise, excluding locked ERROR.
- At TIMEOUT_CYCLES-1 it forces IDLE, clears authenticated and the try count, and issues no ready.
- A timeout coincident with enter: the timeout wins.
REQ-031 Macro undefined: no counter logic; TIMEOUT_CYCLES unused; states persist indefinitely.

Structure
REQ-032 Package atm_pkg SHALL hold the 16-bit state constants, 4-bit status codes, menu_option codes and 3-bit currency codes (USD 0, BTC 1, ETH 2), shared with the ATM datapath.
REQ-033 Sub-module atm_idle_timer (counter with clear/expire) SHALL be instantiated only under ATM_TIMEOUT_EN.

Verification
REQ-034 Login: reset, enter, enter with status 1, enter with status 3 -> states 0x0001->0x0002->0x0004->0x0008; ready high exactly 1 cycle per request; authenticated=1.
REQ-035 Lockout: three PIN requests answered with status 4 -> current_state=0x2000, locked=1; enter and back ignored; reset -> 0x0001, locked=0.
REQ-036 Withdraw: MENU, menu_option=10, enter, enter with status 5 -> 0x0200 then 0x4000; enter -> 0x0008. Answered with status 6 instead -> 0x2000; enter -> 0x0008.
REQ-037 Conflicts:
- enter+back together in TRANSFER -> 0x0008, no ready.
- enter during the outstanding request cycle -> no second ready.
- status 1 returned in WITHDRAW -> 0x2000.
REQ-038 With ATM_TIMEOUT_EN and TIMEOUT_CYCLES=16: sit in MENU 16 cycles with no input -> 0x0001, authenticated=0. Without the macro, same stimulus -> stays 0x0008.
